seg_scan6: RTL and testbench

Six-digit multiplexed seven-segment scanner. Converts a parallel 6×4-bit hex value plus a decimal-point mask into time-multiplexed digit-select and segment drive. Scanning is round-robin, with a ghost-suppression blank interval in each slot. One instance drives each of the H and F source pairs ahead of the display source selector. Its SEG_COM/SEG_DATA outputs connect directly to that selector's H_*/F_* inputs.

---
 rtl/seg_pkg.sv | 19 +
 rtl/seg_hex_decode.sv | 11 +
 rtl/seg_scan6.sv | 94 +++++++++
 tb/tb_seg_scan6.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: idle drive levels and the hex glyph font.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned GLYPH_W    = 7;

  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam logic [5:0] COM_OFF = 6'b111111;

  typedef logic [GLYPH_W-1:0] glyph_t;

  // Segment order {a,b,c,d,e,f,g}; lowercase b and d keep them distinct from 8 and 0.
  localparam glyph_t GLYPH_TAB [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex-to-glyph lookup.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [NIB_W-1:0] code,
  output glyph_t           glyph_c
);

  assign glyph_c = GLYPH_TAB[code];

endmodule

// File: rtl/seg_scan6.sv
// Six-digit round-robin seven-segment scanner with per-slot ghost blanking,
// frame-coherent input snapshot and optional leading-zero suppression.
module seg_scan6
  import seg_pkg::*;
#(
  parameter int unsigned DIV       = 5000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_DIGITS*NIB_W-1:0] DIGITS,
  input  logic [NUM_DIGITS-1:0]       DP,
  input  logic                        BLANK_LZ,
  output logic [NUM_DIGITS-1:0]       SEG_COM,
  output logic [7:0]                  SEG_DATA
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W = 3;

  logic [CNT_W-1:0]              cnt;
  logic [IDX_W-1:0]              idx;
  logic [NUM_DIGITS*NIB_W-1:0]   snap_digits;
  logic [NUM_DIGITS-1:0]         snap_dp;
  logic                          snap_lz;

  logic [NIB_W-1:0]              cur_code;
  glyph_t                        cur_glyph;
  logic [NUM_DIGITS-1:0]         nonzero;
  logic [NUM_DIGITS-1:0]         lz_blank;
  logic                          blank_c;
  logic                          slot_end_c;
  logic                          frame_start_c;

  assign blank_c       = (cnt < CNT_W'(BLANK_CYC));
  assign slot_end_c    = (cnt == CNT_W'(DIV - 1));
  assign frame_start_c = (cnt == '0) && (idx == '0);
  assign cur_code      = snap_digits[{idx, 2'b00} +: NIB_W];

  seg_hex_decode u_decode (
    .code    (cur_code),
    .glyph_c (cur_glyph)
  );

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    nonzero  = '0;
    lz_blank = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nonzero[i] = |snap_digits[i*NIB_W +: NIB_W];
    end
    lz_blank[5] = snap_lz & ~nonzero[5];
    lz_blank[4] = lz_blank[5] & ~nonzero[4];
    lz_blank[3] = lz_blank[4] & ~nonzero[3];
    lz_blank[2] = lz_blank[3] & ~nonzero[2];
    lz_blank[1] = lz_blank[2] & ~nonzero[1];
    lz_blank[0] = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt         <= '0;
      idx         <= '0;
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_lz     <= 1'b0;
      SEG_COM     <= COM_OFF;
      SEG_DATA    <= SEG_OFF;
    end else begin
      if (slot_end_c) begin
        cnt <= '0;
        idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      // Snapshot lands inside digit 0's blank interval, so a frame never tears.
      if (frame_start_c) begin
        snap_digits <= DIGITS;
        snap_dp     <= DP;
        snap_lz     <= BLANK_LZ;
      end

      if (blank_c) begin
        SEG_COM  <= COM_OFF;
        SEG_DATA <= SEG_OFF;
      end else begin
        SEG_COM  <= ~(NUM_DIGITS'(1) << idx);
        SEG_DATA <= {(lz_blank[idx] ? glyph_t'(0) : cur_glyph), snap_dp[idx]};
      end
    end
  end

endmodule

// File: tb/tb_seg_scan6.sv
// Scoreboard bench for seg_scan6 (DIV=8, BLANK_CYC=2): a cycle model pushes expected
// outputs at each clock edge, scenario tasks pop and compare on the falling edge.
module tb_seg_scan6;

  typedef struct packed {
    logic [5:0] com;
    logic [7:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [23:0] digits;
  logic [5:0]  dp;
  logic        blank_lz;
  logic [5:0]  seg_com;
  logic [7:0]  seg_data;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];

  int          m_cnt;
  int          m_idx;
  logic [23:0] m_dig;
  logic [5:0]  m_dp;
  logic        m_lz;

  seg_scan6 #(.DIV(8), .BLANK_CYC(2)) dut (
    .CLK      (clk),
    .RST      (rst),
    .DIGITS   (digits),
    .DP       (dp),
    .BLANK_LZ (blank_lz),
    .SEG_COM  (seg_com),
    .SEG_DATA (seg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ref_glyph(input logic [3:0] c);
    case (c)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  function automatic logic [6:0] exp_segs(input int i);
    if (m_lz && i >= 1 && (m_dig >> (4 * i)) == 24'h0) return 7'h00;
    return ref_glyph(m_dig[4*i +: 4]);
  endfunction

  // Reference model: expected output for each edge is queued as the edge happens.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0;
      m_idx <= 0;
      m_dig <= '0;
      m_dp  <= '0;
      m_lz  <= 1'b0;
      sb.delete();
    end else begin
      if (m_cnt < 2) sb.push_back(exp_t'({6'h3F, 8'h00}));
      else sb.push_back(exp_t'({6'(~(6'b1 << m_idx)), exp_segs(m_idx), m_dp[m_idx]}));
      if (m_cnt == 0 && m_idx == 0) begin
        m_dig <= digits;
        m_dp  <= dp;
        m_lz  <= blank_lz;
      end
      if (m_cnt == 7) begin
        m_cnt <= 0;
        m_idx <= (m_idx == 5) ? 0 : m_idx + 1;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  function automatic int com_digit(input logic [5:0] com);
    for (int i = 0; i < 6; i++) if (com == 6'(~(6'b1 << i))) return i;
    return -1;
  endfunction

  task automatic test_reset();
    exp_t e;
    int   first_act;
    rst = 1'b1; digits = 24'h012345; dp = 6'h00; blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (seg_com !== 6'h3F || seg_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold com=%b data=%h expected com=111111 data=00", seg_com, seg_data);
    end
    rst = 1'b0;
    first_act = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (first_act < 0 && seg_com !== 6'h3F) first_act = k;
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL reset_scan cycle %0d no expected entry", k);
      end else begin
        e = sb.pop_front();
        if ({seg_com, seg_data} !== e) begin
          errors++;
          $display("FAIL reset_scan cycle %0d com=%b data=%h expected com=%b data=%h",
                   k, seg_com, seg_data, e.com, e.data);
        end
      end
    end
    checks++;
    if (first_act != 2) begin
      errors++; $display("FAIL first_active got cycle %0d expected cycle 2", first_act);
    end
    checks++;
    if (seg_com !== 6'b111011) begin
      errors++; $display("FAIL pre_reset_active com=%b expected 111011", seg_com);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (seg_com !== 6'h3F || seg_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_async com=%b data=%h expected com=111111 data=00", seg_com, seg_data);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (seg_com !== 6'h3F || seg_data !== 8'h00) begin
        errors++;
        $display("FAIL reset_held cycle %0d com=%b data=%h expected com=111111 data=00",
                 k, seg_com, seg_data);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_cadence();
    exp_t        e;
    logic [47:0] exp_ord = {6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E};
    logic [5:0]  order[12];
    logic [5:0]  prev = 6'h3F;
    int          order_n = 0;
    int          d0_cnt = 0;
    int          t3e[2] = '{-1, -1};
    int          n3e = 0;
    for (int k = 0; k < 96; k++) begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL cadence cycle %0d no expected entry", k);
      end else begin
        e = sb.pop_front();
        if ({seg_com, seg_data} !== e) begin
          errors++;
          $display("FAIL cadence cycle %0d com=%b data=%h expected com=%b data=%h",
                   k, seg_com, seg_data, e.com, e.data);
        end
      end
      if (k < 48 && seg_com === 6'b111110) d0_cnt++;
      if (seg_com === 6'b111110) begin
        checks++;
        if (seg_data !== 8'hB6) begin
          errors++; $display("FAIL cadence_digit0 data=%h expected b6", seg_data);
        end
      end
      if (prev === 6'h3F && seg_com !== 6'h3F) begin
        if (order_n < 12) order[order_n] = seg_com;
        order_n++;
        if (seg_com === 6'b111110 && n3e < 2) begin t3e[n3e] = k; n3e++; end
      end
      prev = seg_com;
    end
    checks++;
    if (d0_cnt != 6) begin
      errors++; $display("FAIL cadence_digit0_cycles got %0d expected 6", d0_cnt);
    end
    checks++;
    if (order_n != 12) begin
      errors++; $display("FAIL cadence_slot_count got %0d expected 12", order_n);
    end
    for (int i = 0; i < 12 && i < order_n; i++) begin
      checks++;
      if (order[i] !== exp_ord[6*(i%6) +: 6]) begin
        errors++;
        $display("FAIL cadence_order slot %0d com=%b expected %b", i, order[i], exp_ord[6*(i%6) +: 6]);
      end
    end
    checks++;
    if (t3e[1] - t3e[0] != 48) begin
      errors++; $display("FAIL frame_period got %0d expected 48", t3e[1] - t3e[0]);
    end
  endtask

  task automatic test_blank_gap();
    exp_t       e;
    int         run = 0;
    bit         seen_act = 1'b0;
    logic [5:0] last_act = 6'h3F;
    for (int k = 0; k < 96; k++) begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL gap cycle %0d no expected entry", k);
      end else begin
        e = sb.pop_front();
        if ({seg_com, seg_data} !== e) begin
          errors++;
          $display("FAIL gap cycle %0d com=%b data=%h expected com=%b data=%h",
                   k, seg_com, seg_data, e.com, e.data);
        end
      end
      checks++;
      if ($countones(~seg_com) > 1) begin
        errors++; $display("FAIL overlap cycle %0d com=%b expected at most one low", k, seg_com);
      end
      if (seg_com === 6'h3F) begin
        run++;
        checks++;
        if (seg_data !== 8'h00) begin
          errors++; $display("FAIL dark_data cycle %0d data=%h expected 00", k, seg_data);
        end
      end else begin
        if (seen_act && seg_com !== last_act) begin
          checks++;
          if (run != 2) begin
            errors++; $display("FAIL gap_len cycle %0d got %0d expected 2", k, run);
          end
        end
        run = 0;
        seen_act = 1'b1;
        last_act = seg_com;
      end
    end
  endtask

  task automatic test_leading_zero();
    exp_t       e;
    int         d;
    logic [7:0] want;
    for (int pass = 0; pass < 2; pass++) begin
      digits = 24'h000070; dp = 6'b000001; blank_lz = (pass == 0);
      for (int k = 0; k < 96; k++) begin
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL lz cycle %0d no expected entry", k);
        end else begin
          e = sb.pop_front();
          if ({seg_com, seg_data} !== e) begin
            errors++;
            $display("FAIL lz pass %0d cycle %0d com=%b data=%h expected com=%b data=%h",
                     pass, k, seg_com, seg_data, e.com, e.data);
          end
        end
        d = com_digit(seg_com);
        if (k >= 48 && d >= 0) begin
          if (d == 0) want = 8'hFD;
          else if (d == 1) want = 8'hE0;
          else want = (pass == 0) ? 8'h00 : 8'hFC;
          checks++;
          if (seg_data !== want) begin
            errors++;
            $display("FAIL lz_digit pass %0d digit %0d data=%h expected %h", pass, d, seg_data, want);
          end
        end
      end
    end
  endtask

  task automatic test_snapshot();
    exp_t e;
    bit   found = 1'b0;
    bit   new_frame = 1'b0;
    logic [7:0] want;
    digits = 24'h111111; dp = 6'h00; blank_lz = 1'b0;
    for (int k = 0; k < 144 && !found; k++) begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL snap_pre cycle %0d no expected entry", k);
      end else begin
        e = sb.pop_front();
        if ({seg_com, seg_data} !== e) begin
          errors++;
          $display("FAIL snap_pre cycle %0d com=%b data=%h expected com=%b data=%h",
                   k, seg_com, seg_data, e.com, e.data);
        end
      end
      if (k >= 96 && seg_com === 6'b110111) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL snap_wait digit 3 never active expected within 48 cycles");
    end
    digits = 24'h222222;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
        errors++; $display("FAIL snap cycle %0d no expected entry", k);
      end else begin
        e = sb.pop_front();
        if ({seg_com, seg_data} !== e) begin
          errors++;
          $display("FAIL snap cycle %0d com=%b data=%h expected com=%b data=%h",
                   k, seg_com, seg_data, e.com, e.data);
        end
      end
      if (seg_com === 6'b111110) new_frame = 1'b1;
      if (seg_com !== 6'h3F) begin
        want = new_frame ? 8'hDA : 8'h60;
        checks++;
        if (seg_data !== want) begin
          errors++; $display("FAIL snap_value cycle %0d data=%h expected %h", k, seg_data, want);
        end
      end
    end
    checks++;
    if (!new_frame) begin
      errors++; $display("FAIL snap_next_frame not reached expected digit 0 within 60 cycles");
    end
  endtask

  task automatic test_glyph_sweep();
    exp_t       e;
    logic [3:0] c;
    for (int code = 0; code < 16; code++) begin
      c = 4'(code);
      digits = {20'h00000, c}; dp = 6'h00; blank_lz = 1'b0;
      for (int k = 0; k < 96; k++) begin
        @(negedge clk);
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL sweep cycle %0d no expected entry", k);
        end else begin
          e = sb.pop_front();
          if ({seg_com, seg_data} !== e) begin
            errors++;
            $display("FAIL sweep code %h cycle %0d com=%b data=%h expected com=%b data=%h",
                     c, k, seg_com, seg_data, e.com, e.data);
          end
        end
        if (k >= 48 && seg_com === 6'b111110) begin
          checks++;
          if (seg_data[7:1] !== ref_glyph(c)) begin
            errors++;
            $display("FAIL glyph code %h segs=%b expected %b", c, seg_data[7:1], ref_glyph(c));
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cadence();
    test_blank_gap();
    test_leading_zero();
    test_snapshot();
    test_glyph_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
